// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
//
// Parametrised dual-read, single-write register file for the RISC datapath.
// Read addresses come from decode and the write port from writeback. Both read
// ports are registered and return data one cycle after the address is
// presented. A run-time clear sequencer zeroes the array one entry per cycle
// while busy is high.
//
// Parameters:
//   DATA_W   - register width in bits
//   ADDR_W   - width of every address port
//   DEPTH    - number of registers (2 .. 2**ADDR_W)
//   ZERO_REG - 1: register 0 reads as zero and ignores writes
//
// Ports:
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset (control and read regs only)
//   rd1_addr  in   read port 1 address
//   rd1_data  out  read port 1 data, registered
//   rd2_addr  in   read port 2 address
//   rd2_data  out  read port 2 data, registered
//   wr_en     in   write enable
//   wr_addr   in   write address
//   wr_data   in   write data
//   clr_req   in   one-cycle pulse that starts a clear of all registers
//   busy      out  high while a clear is in progress
//
// Build option:
//   RF_BYPASS_EN - when defined, a committed write to the address being read
//                  in the same cycle is forwarded to the read output
//                  (write-first). When undefined, reads are read-first.
// -----------------------------------------------------------------------------
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [0:0]        state_q,    state_d;
  logic [ADDR_W-1:0] ptr_q,      ptr_d;
  logic [DATA_W-1:0] rd1_data_q, rd1_data_d;
  logic [DATA_W-1:0] rd2_data_q, rd2_data_d;

  logic              wr_commit;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_blank;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_X);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a);
  endfunction

  // A write only lands while idle, in range, and not on a hardwired zero.
  always_comb begin
    wr_commit = wr_en && (state_q == ST_IDLE) && in_range(wr_addr) &&
                !is_zero_reg(wr_addr);
  end

  // Clear sequencer: the pointer walks 0 .. DEPTH-1 and never wraps.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Single array write port shared by the clear sequencer and writeback;
  // the two are mutually exclusive because writes only commit while idle.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = '0;
    if (state_q == ST_CLEAR) begin
      mem_we   = 1'b1;
      mem_widx = to_idx(ptr_q);
    end else if (wr_commit) begin
      mem_we    = 1'b1;
      mem_widx  = to_idx(wr_addr);
      mem_wdata = wr_data;
    end
  end

  // Reads are blanked on the edge that starts a clear, on every clear edge,
  // and on the edge that ends it. This keeps the outputs at zero for the whole
  // busy window and avoids returning the pre-clear value of the last entry.
  always_comb begin
    rd_blank = (state_q == ST_CLEAR) || (state_d == ST_CLEAR);
  end

  always_comb begin
    rd1_data_d = '0;
    if (!rd_blank && in_range(rd1_addr) && !is_zero_reg(rd1_addr)) begin
      rd1_data_d = mem_q[to_idx(rd1_addr)];
`ifdef RF_BYPASS_EN
      if (wr_commit && (rd1_addr == wr_addr)) begin
        rd1_data_d = wr_data;
      end
`endif
    end
  end

  always_comb begin
    rd2_data_d = '0;
    if (!rd_blank && in_range(rd2_addr) && !is_zero_reg(rd2_addr)) begin
      rd2_data_d = mem_q[to_idx(rd2_addr)];
`ifdef RF_BYPASS_EN
      if (wr_commit && (rd2_addr == wr_addr)) begin
        rd2_data_d = wr_data;
      end
`endif
    end
  end

  // Array storage: deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  // Control state and registered read outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      rd1_data_q <= '0;
      rd2_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd1_data_q <= rd1_data_d;
      rd2_data_q <= rd2_data_d;
    end
  end

  assign rd1_data = rd1_data_q;
  assign rd2_data = rd2_data_q;
  assign busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_reg_file_param.sv
// -----------------------------------------------------------------------------
// tb_reg_file_param
//
// Drives three register-file builds from one shared stimulus stream:
//   u0: DEPTH=32, ZERO_REG=1   u1: DEPTH=32, ZERO_REG=0   u2: DEPTH=16, ZERO_REG=1
// A behavioural model holds each build's register contents and clear progress
// and predicts the read outputs and busy flag; a compare process checks them
// every cycle, and the directed sequence adds hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_reg_file_param;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rd1_addr = '0;
  logic [4:0]  rd2_addr = '0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        clr_req = 1'b0;

  logic [31:0] rd1_o [NI];
  logic [31:0] rd2_o [NI];
  logic        busy_o [NI];

  always #5 clk = ~clk;

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rd1_addr(rd1_addr), .rd1_data(rd1_o[0]),
    .rd2_addr(rd2_addr), .rd2_data(rd2_o[0]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy_o[0]));

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(0)) u1 (
    .clk(clk), .rst_n(rst_n), .rd1_addr(rd1_addr), .rd1_data(rd1_o[1]),
    .rd2_addr(rd2_addr), .rd2_data(rd2_o[1]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy_o[1]));

  reg_file_param #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .ZERO_REG(1)) u2 (
    .clk(clk), .rst_n(rst_n), .rd1_addr(rd1_addr), .rd1_data(rd1_o[2]),
    .rd2_addr(rd2_addr), .rd2_data(rd2_o[2]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_req(clr_req), .busy(busy_o[2]));

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int dep [NI] = '{32, 32, 16};
  bit zr  [NI] = '{1'b1, 1'b0, 1'b1};

  // Model state: contents with a "known" flag (array is undefined until
  // written or cleared), clear activity and how many entries it has zeroed.
  logic [31:0] m_mem [NI][32];
  bit          m_kn  [NI][32];
  bit          m_busy [NI] = '{default: 1'b0};
  int          m_cnt  [NI] = '{default: 0};
  logic [31:0] e1 [NI] = '{default: 32'h0};
  logic [31:0] e2 [NI] = '{default: 32'h0};
  bit          k1 [NI] = '{default: 1'b1};
  bit          k2 [NI] = '{default: 1'b1};
  bit          wok [NI];
  bit          st  [NI];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_read(input int i, input logic [4:0] a,
                                     input bit wrote, output logic [31:0] v,
                                     output bit k);
    if (int'(a) >= dep[i] || (zr[i] && a == 5'd0)) begin
      v = 32'h0; k = 1'b1;
    end else if (BYP && wrote && a == wr_addr) begin
      v = wr_data; k = 1'b1;
    end else begin
      v = m_mem[i][a]; k = m_kn[i][a];
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_busy[i] = 1'b0; m_cnt[i] = 0;
        e1[i] = 32'h0; e2[i] = 32'h0; k1[i] = 1'b1; k2[i] = 1'b1;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        wok[i] = !m_busy[i] && wr_en && (int'(wr_addr) < dep[i]) &&
                 !(zr[i] && wr_addr == 5'd0);
        st[i]  = !m_busy[i] && clr_req;
        model_read(i, rd1_addr, wok[i], e1[i], k1[i]);
        model_read(i, rd2_addr, wok[i], e2[i], k2[i]);
        if (m_busy[i] || st[i]) begin
          e1[i] = 32'h0; e2[i] = 32'h0; k1[i] = 1'b1; k2[i] = 1'b1;
        end
        if (wok[i]) begin
          m_mem[i][wr_addr] = wr_data; m_kn[i][wr_addr] = 1'b1;
        end
        if (m_busy[i]) begin
          m_mem[i][m_cnt[i]] = 32'h0; m_kn[i][m_cnt[i]] = 1'b1;
          m_cnt[i]++;
          if (m_cnt[i] == dep[i]) m_busy[i] = 1'b0;
        end else if (st[i]) begin
          m_busy[i] = 1'b1; m_cnt[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("u%0d_busy", i), 32'(busy_o[i]), 32'(m_busy[i]));
        if (k1[i]) check($sformatf("u%0d_rd1", i), rd1_o[i], e1[i]);
        if (k2[i]) check($sformatf("u%0d_rd2", i), rd2_o[i], e2[i]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc [NI];
    int n;

    // Reset state
    step(); step();
    chk_en = 1'b1;
    check("rst_rd1", rd1_o[0], 32'h0);
    check("rst_rd2", rd2_o[0], 32'h0);
    check("rst_busy", 32'(busy_o[0]), 32'h0);
    rst_n = 1'b1;
    step();

    // Clear then read: busy lasts DEPTH cycles
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    bc = '{default: 0};
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < NI; i++) bc[i] += int'(busy_o[i]);
      step();
    end
    check("busy_len_u0", 32'(bc[0]), 32'd32);
    check("busy_len_u1", 32'(bc[1]), 32'd32);
    check("busy_len_u2", 32'(bc[2]), 32'd16);
    rd1_addr = 5'd5; rd2_addr = 5'd31;
    step();
    check("clr_r5", rd1_o[0], 32'h0);
    check("clr_r31", rd2_o[0], 32'h0);

    // Basic write/read
    wr(5'd2, 32'h0000_0008);
    wr(5'd3, 32'h0000_0005);
    rd1_addr = 5'd2; rd2_addr = 5'd3;
    step();
    check("wr_r2", rd1_o[0], 32'h8);
    check("wr_r3", rd2_o[0], 32'h5);

    // Zero register
    wr(5'd0, 32'hDEAD_BEEF);
    rd1_addr = 5'd0;
    step();
    check("zero_u0", rd1_o[0], 32'h0);
    check("zero_u1", rd1_o[1], 32'hDEAD_BEEF);

    // Same-cycle read/write
    wr(5'd7, 32'h11);
    rd1_addr = 5'd7;
    wr(5'd7, 32'h22);
    check("rdw_edge", rd1_o[0], BYP ? 32'h22 : 32'h11);
    step();
    check("rdw_next", rd1_o[0], 32'h22);

    // Clear interaction: write with clr_req commits then is zeroed;
    // writes while busy are lost
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hAA; clr_req = 1'b1;
    step();
    clr_req = 1'b0; wr_addr = 5'd9; wr_data = 32'h55;
    n = 0;
    while (busy_o[0] && n < 50) begin
      step();
      n++;
    end
    check("clr_ends", 32'(busy_o[0]), 32'h0);
    wr_en = 1'b0;
    rd1_addr = 5'd4; rd2_addr = 5'd9;
    step();
    check("clr_r4", rd1_o[0], 32'h0);
    check("clr_r9", rd2_o[0], 32'h0);

    // Reset mid-clear
    wr(5'd20, 32'h77);
    wr(5'd1, 32'h33);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("midrst_busy_u%0d", i), 32'(busy_o[i]), 32'h0);
    check("midrst_rd1", rd1_o[0], 32'h0);
    step();
    rst_n = 1'b1;
    rd1_addr = 5'd1; rd2_addr = 5'd20;
    step();
    check("midrst_r1", rd1_o[0], 32'h0);
    check("midrst_r20", rd2_o[0], 32'h77);
    check("d16_r1", rd1_o[2], 32'h0);
    check("d16_r20", rd2_o[2], 32'h0);

    // Out-of-range write dropped in the DEPTH=16 build
    rd1_addr = 5'd20;
    wr(5'd20, 32'h99);
    step();
    check("oor_u0", rd1_o[0], 32'h99);
    check("oor_u2", rd1_o[2], 32'h0);

    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the CPU's 32x32 dual-read register file.
- Configurable data width and depth.
- Adds registered reads with 1-cycle latency, an optional hardwired zero register, and a run-time clear sequencer with a busy flag.
- Optional same-cycle write-to-read bypass.
- Sits between decode (read addresses) and writeback (write port) of the RISC datapath.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, width of every address port
DEPTH, 32, number of registers; legal range 2..2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is an ordinary register

Ports:
clk  input  1  single clock; all state changes on its rising edge
rst_n  input  1  asynchronous, active-low reset
rd1_addr  input  ADDR_W  read port 1 address
rd1_data  output  DATA_W  read port 1 data, registered
rd2_addr  input  ADDR_W  read port 2 address
rd2_data  output  DATA_W  read port 2 data, registered
wr_en  input  1  write enable
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
clr_req  input  1  one-cycle pulse that starts a clear of all registers
busy  output  1  high while a clear is in progress

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous):
  - rd1_data=0, rd2_data=0, busy=0.
  - FSM goes to IDLE; clear pointer = 0.
  - Array contents are NOT reset. They stay undefined until written or cleared.
- Write: on a rising edge with wr_en=1, state IDLE, and wr_addr<DEPTH, set array[wr_addr] = wr_data.
  - Writes to wr_addr>=DEPTH are dropped.
  - Writes to address 0 are dropped when ZERO_REG=1.
- Read: on every rising edge, rdN_data <= value at rdN_addr. The value appears 1 cycle after the address is presented.
  - Forced to 0 if rdN_addr>=DEPTH.
  - Forced to 0 if ZERO_REG=1 and rdN_addr==0.
  - Forced to 0 while busy.
- Read-during-write to the same address in the same cycle: governed by the optional feature below.
- Both read ports are independent and may use the same address.
- FSM states:
  - IDLE: clr_req=1 moves to CLEAR and sets ptr=0. busy rises on the same edge.
  - CLEAR: each cycle sets array[ptr]=0 and ptr=ptr+1.
    - When ptr==DEPTH-1, the last register is zeroed and the FSM returns to IDLE. busy falls on that edge.
    - busy is therefore high for exactly DEPTH cycles.
- During CLEAR:
  - wr_en is ignored and the write is lost. Writeback must stall on busy.
  - clr_req is ignored.
  - Read outputs are 0.
- clr_req and wr_en high in the same IDLE cycle: the write commits first, then the clear starts and zeroes it.
- Reset asserted mid-clear:
  - FSM returns to IDLE, busy=0, ptr=0.
  - Registers already cleared stay 0; the rest keep their old contents.
- ptr width is ADDR_W. It never wraps past DEPTH-1.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: if wr_en commits a write (per the write rules above) and rdN_addr==wr_addr in the same cycle, rdN_data takes wr_data on that edge (write-first).
  - No bypass for dropped writes. This covers zero-register, out-of-range and busy writes.
- Undefined: the read returns the old array value (read-first). The new value is visible one cycle later.

Test Plan:
- Clear then read: rst_n low then high, pulse clr_req. busy must be high exactly 32 cycles. Afterwards rd1_addr=5, rd2_addr=31 return 0 and 0.
- Basic write/read: write 0x00000008 to r2 and 0x00000005 to r3 on consecutive cycles. Then rd1_addr=2, rd2_addr=3 gives rd1_data=0x8, rd2_data=0x5 one cycle later.
- Zero register: with ZERO_REG=1, write 0xDEADBEEF to r0. rd1_addr=0 returns 0. Repeat with ZERO_REG=0: returns 0xDEADBEEF.
- Same-cycle read/write: r7 holds 0x11, then write 0x22 to r7 with rd1_addr=7.
  - With RF_BYPASS_EN: rd1_data=0x22 on that edge.
  - Without RF_BYPASS_EN: rd1_data=0x11 on that edge, then 0x22 the next cycle.
- Clear interaction: write 0xAA to r4 in the same cycle as clr_req. Then assert wr_en for r9=0x55 while busy. After busy falls, r4=0 and r9=0.
- Reset mid-clear: with r20=0x77 and r1=0x33, pulse clr_req. Assert rst_n low after 10 busy cycles.
  - busy drops immediately.
  - After release, r1 reads 0 and r20 reads 0x77.
  - DEPTH=16 build: rd1_addr=20 reads 0, and a write to address 20 is dropped.
